physics_step_scheduler: RTL and testbench

- Sequences one physics frame: on each frame tick it runs SUBSTEPS substeps.
- Each substep launches all wheel update engines in parallel, waits for every wheel result, then launches the body/axle update and waits for it.
- Sits between the frame-timing logic and the wheel/body update engines.
- Also tracks frame overruns and stalled engines through a watchdog.

---
 rtl/physics_step_scheduler.sv | 166 ++++++++++++++++
 tb/tb_physics_step_scheduler.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/physics_step_scheduler.sv
// Frame sequencer: per tick runs SUBSTEPS rounds of (all wheel engines in parallel -> body engine),
// with tick overrun accounting and a watchdog that aborts a stalled frame.
module pss_wheel_lane (
  input  logic clk_in,
  input  logic rst_in,
  input  logic launch,
  input  logic clr,
  input  logic cap,
  input  logic done_pulse,
  output logic begin_pulse,
  output logic done_q
);
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      begin_pulse <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      begin_pulse <= launch;
      if (clr)      done_q <= 1'b0;
      else if (cap) done_q <= done_q | done_pulse;
    end
  end
endmodule

module physics_step_scheduler #(
  parameter int NUM_WHEELS     = 2,
  parameter int SUBSTEPS       = 4,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int CNT_SIZE       = 16
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        frame_tick_in,
  input  logic                        enable_in,
  output logic [NUM_WHEELS-1:0]       wheel_begin_out,
  input  logic [NUM_WHEELS-1:0]       wheel_done_in,
  output logic                        body_begin_out,
  input  logic                        body_done_in,
  output logic [$clog2(SUBSTEPS):0]   substep_idx_out,
  output logic                        busy_out,
  output logic                        step_done_out,
  output logic [CNT_SIZE-1:0]         frame_count_out,
  output logic [CNT_SIZE-1:0]         overrun_count_out,
  output logic                        timeout_out
);
  localparam int SW  = $clog2(SUBSTEPS) + 1;
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0]  SUB_LAST = SW'(SUBSTEPS - 1);
  localparam logic [WDW-1:0] WD_LAST  = WDW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, LAUNCH_WHEELS, WAIT_WHEELS, LAUNCH_BODY, WAIT_BODY, FINISH
  } state_t;

  state_t                state, state_n;
  logic                  pend, pend_n;
  logic [SW-1:0]         sub_n;
  logic [WDW-1:0]        wd, wd_n;
  logic                  to_n;
  logic [CNT_SIZE-1:0]   frm_n, ovr_n;
  logic                  mask_clr, mask_cap;
  logic [NUM_WHEELS-1:0] mask;

  pss_wheel_lane u_lane [NUM_WHEELS-1:0] (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .launch      (state_n == LAUNCH_WHEELS),
    .clr         (mask_clr),
    .cap         (mask_cap),
    .done_pulse  (wheel_done_in),
    .begin_pulse (wheel_begin_out),
    .done_q      (mask)
  );

  always_comb begin
    state_n  = state;
    pend_n   = pend;
    sub_n    = substep_idx_out;
    wd_n     = wd;
    to_n     = timeout_out;
    frm_n    = frame_count_out;
    ovr_n    = overrun_count_out;
    mask_clr = 1'b0;
    mask_cap = 1'b0;

    // Ticks that cannot start a frame right now are parked; a second parked tick is an overrun.
    if (frame_tick_in && (state != IDLE || !enable_in)) begin
      if (pend) ovr_n = (&overrun_count_out) ? overrun_count_out : overrun_count_out + 1'b1;
      else      pend_n = 1'b1;
    end

    case (state)
      IDLE: begin
        if (enable_in && (frame_tick_in || pend)) begin
          pend_n  = 1'b0;
          sub_n   = '0;
          state_n = LAUNCH_WHEELS;
        end
      end
      LAUNCH_WHEELS: begin
        mask_clr = 1'b1;
        wd_n     = '0;
        state_n  = WAIT_WHEELS;
      end
      WAIT_WHEELS: begin
        mask_cap = 1'b1;
        wd_n     = wd + 1'b1;
        if (&(mask | wheel_done_in)) begin
          state_n = LAUNCH_BODY;
        end else if (wd == WD_LAST) begin
          to_n     = 1'b1;
          mask_clr = 1'b1;
          state_n  = IDLE;
        end
      end
      LAUNCH_BODY: begin
        wd_n    = '0;
        state_n = WAIT_BODY;
      end
      WAIT_BODY: begin
        wd_n = wd + 1'b1;
        if (body_done_in) begin
          if (substep_idx_out == SUB_LAST) begin
            frm_n   = frame_count_out + 1'b1;
            state_n = FINISH;
          end else begin
            sub_n   = substep_idx_out + 1'b1;
            state_n = LAUNCH_WHEELS;
          end
        end else if (wd == WD_LAST) begin
          to_n    = 1'b1;
          state_n = IDLE;
        end
      end
      FINISH:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Pulses and busy are registered from the next state so they line up with the state they flag.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state             <= IDLE;
      pend              <= 1'b0;
      substep_idx_out   <= '0;
      wd                <= '0;
      timeout_out       <= 1'b0;
      frame_count_out   <= '0;
      overrun_count_out <= '0;
      body_begin_out    <= 1'b0;
      step_done_out     <= 1'b0;
      busy_out          <= 1'b0;
    end else begin
      state             <= state_n;
      pend              <= pend_n;
      substep_idx_out   <= sub_n;
      wd                <= wd_n;
      timeout_out       <= to_n;
      frame_count_out   <= frm_n;
      overrun_count_out <= ovr_n;
      body_begin_out    <= (state_n == LAUNCH_BODY);
      step_done_out     <= (state_n == FINISH);
      busy_out          <= (state_n != IDLE);
    end
  end
endmodule

// File: tb/tb_physics_step_scheduler.sv
// Directed bench for physics_step_scheduler: engine responders, a frame-level reference model
// compared every cycle, and literal cycle expectations for each scenario.
module tb_physics_step_scheduler;
  localparam int NW = 2, SS = 2, TO = 64, CW = 16;
  localparam int SW = $clog2(SS) + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, tick, en;
  logic [NW-1:0] wheel_done, man_wd, auto_wd;
  logic          body_done, auto_bd;
  logic [NW-1:0] wheel_begin;
  logic          body_begin, busy, step_done, timeout;
  logic [SW-1:0] sub_idx;
  logic [CW-1:0] frame_count, overrun_count;

  assign wheel_done = man_wd | auto_wd;
  assign body_done  = auto_bd;

  physics_step_scheduler #(.NUM_WHEELS(NW), .SUBSTEPS(SS), .TIMEOUT_CYCLES(TO), .CNT_SIZE(CW)) dut (
    .clk_in(clk), .rst_in(rst), .frame_tick_in(tick), .enable_in(en),
    .wheel_begin_out(wheel_begin), .wheel_done_in(wheel_done),
    .body_begin_out(body_begin), .body_done_in(body_done),
    .substep_idx_out(sub_idx), .busy_out(busy), .step_done_out(step_done),
    .frame_count_out(frame_count), .overrun_count_out(overrun_count), .timeout_out(timeout)
  );

  int cyc = 0;
  int checks = 0, errors = 0;
  bit chk_en = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // Engine responders: a begin seen in cycle c yields a done pulse in cycle c+lat (lat 0 = never).
  int wlat[NW];
  int blat;
  int wdue[NW] = '{-1, -1};
  int bdue = -1;
  bit auto_w_on;
  initial begin
    auto_wd = '0; auto_bd = 1'b0;
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < NW; i++) auto_wd[i] = (cyc == wdue[i]);
      auto_bd = (cyc == bdue);
    end
  end

  // Reference model: tracks which engines are still outstanding in the current substep.
  bit m_busy, m_lw, m_lb, m_fin, m_bw, m_pend, m_to;
  logic [NW-1:0] m_out;
  int m_sub, m_frames, m_over, m_age;

  task automatic model_step();
    bit nlw, nlb, nfin;
    nlw = 0; nlb = 0; nfin = 0;
    if (rst) begin
      m_busy = 0; m_lw = 0; m_lb = 0; m_fin = 0; m_bw = 0; m_pend = 0; m_to = 0;
      m_out = '0; m_sub = 0; m_frames = 0; m_over = 0; m_age = 0;
      return;
    end
    if (tick && (m_busy || !en)) begin
      if (m_pend) begin if (m_over < 65535) m_over++; end
      else m_pend = 1;
    end
    if (!m_busy) begin
      if (en && (tick || m_pend)) begin m_pend = 0; m_sub = 0; m_busy = 1; nlw = 1; end
    end else if (m_lw) begin
      m_out = '1; m_age = 0;
    end else if (m_lb) begin
      m_bw = 1; m_age = 0;
    end else if (m_fin) begin
      m_busy = 0;
    end else if (m_out != 0) begin
      m_out = m_out & ~wheel_done;
      if (m_out == 0) nlb = 1;
      else if (m_age == TO - 1) begin m_busy = 0; m_out = '0; m_to = 1; end
      else m_age++;
    end else if (m_bw) begin
      if (body_done) begin
        m_bw = 0;
        if (m_sub == SS - 1) begin nfin = 1; m_frames = (m_frames + 1) % 65536; end
        else begin m_sub++; nlw = 1; end
      end else if (m_age == TO - 1) begin m_busy = 0; m_bw = 0; m_to = 1; end
      else m_age++;
    end
    m_lw = nlw; m_lb = nlb; m_fin = nfin;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Per-cycle compare, event logging and responder scheduling.
  int wb_q[$], bb_q[$], sd_q[$], bb_sub[$];
  int to_cyc = -1;
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("wheel_begin", 64'(wheel_begin), m_lw ? 64'(NW'('1)) : 64'd0);
      chk("body_begin",  64'(body_begin),  64'(m_lb));
      chk("step_done",   64'(step_done),   64'(m_fin));
      chk("busy",        64'(busy),        64'(m_busy));
      chk("substep_idx", 64'(sub_idx),     64'(m_sub));
      chk("frame_count", 64'(frame_count), 64'(m_frames));
      chk("overrun",     64'(overrun_count), 64'(m_over));
      chk("timeout",     64'(timeout),     64'(m_to));
    end
    if (wheel_begin != 0) wb_q.push_back(cyc);
    if (body_begin) begin bb_q.push_back(cyc); bb_sub.push_back(int'(sub_idx)); end
    if (step_done) sd_q.push_back(cyc);
    if (timeout === 1'b1 && to_cyc < 0) to_cyc = cyc;
    for (int i = 0; i < NW; i++)
      if (wheel_begin[i] && auto_w_on && wlat[i] > 0) wdue[i] = cyc + wlat[i];
    if (body_begin && blat > 0) bdue = cyc + blat;
  end

  task automatic clr_q();
    wb_q.delete(); bb_q.delete(); sd_q.delete(); bb_sub.delete();
  endtask

  task automatic do_tick(output int t);
    @(posedge clk); #1; tick = 1; t = cyc;
    @(posedge clk); #1; tick = 0;
  endtask

  task automatic wait_sd(input int n, input int lim, input string nm);
    int k = 0;
    while (sd_q.size() < n && k < lim) begin @(negedge clk); #1; k++; end
    chk(nm, 64'(sd_q.size() >= n), 64'd1);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int t, k;
  initial begin
    rst = 1; tick = 0; en = 1; man_wd = '0; auto_w_on = 1;
    wlat[0] = 5; wlat[1] = 5; blat = 3;
    @(posedge clk); chk_en = 1;
    @(posedge clk); #1; rst = 0;
    @(negedge clk); #1;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_frames", 64'(frame_count), 64'd0);
    chk("reset_begin", 64'(wheel_begin), 64'd0);

    // 1: basic frame, wheels 5 cycles, body 3 cycles
    idle_cycles(3); clr_q();
    do_tick(t);
    wait_sd(1, 100, "t1_wait");
    @(negedge clk); #1;
    chk("t1_wb0", 64'(wb_q[0]), 64'(t + 1));
    chk("t1_wb1", 64'(wb_q[1]), 64'(t + 11));
    chk("t1_bb0", 64'(bb_q[0]), 64'(t + 7));
    chk("t1_bb1", 64'(bb_q[1]), 64'(t + 17));
    chk("t1_sd",  64'(sd_q[0]), 64'(t + 21));
    chk("t1_sub0", 64'(bb_sub[0]), 64'd0);
    chk("t1_sub1", 64'(bb_sub[1]), 64'd1);
    chk("t1_frames", 64'(frame_count), 64'd1);

    // 2: staggered and duplicate wheel dones
    idle_cycles(3); clr_q(); auto_w_on = 0;
    do_tick(t);
    while (cyc <= t + 11) begin
      man_wd[0] = (cyc == t + 3 || cyc == t + 5);
      man_wd[1] = (cyc == t + 10);
      if (cyc == t + 11) auto_w_on = 1;
      @(posedge clk); #1;
    end
    man_wd = '0;
    chk("t2_bb_count_mid", 64'(bb_q.size()), 64'd1);
    wait_sd(1, 100, "t2_wait");
    chk("t2_bb0", 64'(bb_q[0]), 64'(t + 11));
    chk("t2_bb_total", 64'(bb_q.size()), 64'd2);
    chk("t2_frames", 64'(frame_count), 64'd2);

    // 3: three ticks during a busy frame
    idle_cycles(3); clr_q();
    do_tick(t);
    while (cyc <= t + 8) begin
      tick = (cyc == t + 3 || cyc == t + 5 || cyc == t + 8);
      @(posedge clk); #1;
    end
    tick = 0;
    wait_sd(2, 150, "t3_wait");
    chk("t3_overrun", 64'(overrun_count), 64'd2);
    chk("t3_sd0", 64'(sd_q[0]), 64'(t + 21));
    chk("t3_wb2", 64'(wb_q[2]), 64'(t + 23));
    chk("t3_sd1", 64'(sd_q[1]), 64'(t + 43));
    chk("t3_frames", 64'(frame_count), 64'd4);

    // 4: wheel1 never answers -> watchdog abort
    idle_cycles(3); clr_q(); wlat[1] = 0;
    do_tick(t);
    k = 0;
    while (to_cyc < 0 && k < 120) begin @(negedge clk); #1; k++; end
    chk("t4_to_cycle", 64'(to_cyc), 64'(t + 66));
    chk("t4_busy", 64'(busy), 64'd0);
    idle_cycles(4);
    chk("t4_no_sd", 64'(sd_q.size()), 64'd0);
    chk("t4_frames", 64'(frame_count), 64'd4);
    chk("t4_timeout", 64'(timeout), 64'd1);
    wlat[1] = 5;

    // 5: tick while disabled is held until enable rises
    idle_cycles(3); clr_q(); en = 0;
    do_tick(t);
    while (cyc < t + 5) begin @(posedge clk); #1; end
    chk("t5_no_begin", 64'(wb_q.size()), 64'd0);
    en = 1;
    wait_sd(1, 100, "t5_wait");
    chk("t5_wb0", 64'(wb_q[0]), 64'(t + 6));
    chk("t5_frames", 64'(frame_count), 64'd5);

    // 6: reset during WAIT_BODY; the late body done must be ignored
    idle_cycles(3); clr_q();
    do_tick(t);
    k = 0;
    while (bb_q.size() < 1 && k < 50) begin @(negedge clk); #1; k++; end
    chk("t6_bb_seen", 64'(bb_q.size()), 64'd1);
    @(posedge clk); #1; rst = 1;
    @(posedge clk); #1; rst = 0;
    @(negedge clk); #1;
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_frames", 64'(frame_count), 64'd0);
    chk("t6_overrun", 64'(overrun_count), 64'd0);
    chk("t6_timeout", 64'(timeout), 64'd0);
    idle_cycles(10);
    chk("t6_no_wb", 64'(wb_q.size()), 64'd1);
    chk("t6_no_bb", 64'(bb_q.size()), 64'd1);
    chk("t6_no_sd", 64'(sd_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
